bitstream_scheduler: RTL

Sequencer that drives one evaluation of the bitstream neural network. On `start` it captures the N input values, generates N stochastic bitstreams from per-input 8-bit LFSRs for one full 255-cycle window, and counts the 1s returned on the network output, compensating for the network's fixed pipeline latency. It then presents the 8-bit count as the result with a `done` pulse. It sits between the board-level control logic and the network datapath, and replaces free-running stream generation with a deterministic, restartable window.

---
 rtl/bitstream_scheduler_if.sv | 26 ++
 rtl/bitstream_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bitstream_scheduler_if.sv
// Handshake and data bundle between the board control logic / network datapath
// and the bitstream scheduler.
interface bitstream_scheduler_if #(
    parameter int unsigned N_INPUTS = 2
);
    logic                    start;
    logic                    abort;
    logic [N_INPUTS*8-1:0]   in_value;
    logic                    net_bit;
    logic [N_INPUTS-1:0]     in_bits;
    logic                    stream_valid;
    logic                    busy;
    logic                    done;
    logic [7:0]              result;
    logic                    result_valid;

    modport master (
        output start, abort, in_value, net_bit,
        input  in_bits, stream_valid, busy, done, result, result_valid
    );

    modport slave (
        input  start, abort, in_value, net_bit,
        output in_bits, stream_valid, busy, done, result, result_valid
    );
endinterface

// File: rtl/bitstream_scheduler.sv
// One deterministic evaluation of the bitstream network: captures the inputs,
// streams a full 255-cycle LFSR window per input, counts the 1s returned by the
// network after its pipeline latency, and reports the count with a done pulse.
module bitstream_scheduler #(
    parameter int unsigned N_INPUTS   = 2,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    bitstream_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0] WIN_LAST   = 8'd254;
    localparam logic [3:0] DRAIN_LAST = (PIPE_DEPTH == 0) ? 4'd0 : 4'(PIPE_DEPTH - 1);

    state_t        state;
    logic [7:0]    win_cnt;
    logic [3:0]    drain_cnt;
    logic [7:0]    lfsr [N_INPUTS];
    logic [7:0]    val  [N_INPUTS];
    logic [7:0]    acc;
    logic          result_valid;
    logic [N_INPUTS-1:0] in_bits;
    logic          run;
    logic          abort_hit;
    logic          sample_valid;

    function automatic logic [7:0] seed(input int unsigned i);
        return 8'(1 + 29 * i);
    endfunction

    // Maximal Fibonacci LFSR, taps 8,6,5,4 -> period 255
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign run       = (state == RUN);
    assign abort_hit = bus.abort && (state != IDLE);

    // Sequencer: window/drain counting, input capture and LFSR stepping.
    // An abort sampled in DONE still shows that cycle's done, but suppresses result_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            win_cnt      <= '0;
            drain_cnt    <= '0;
            result_valid <= 1'b0;
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                lfsr[i] <= seed(i);
                val[i]  <= '0;
            end
        end else if (abort_hit) begin
            state        <= IDLE;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= RUN;
                        win_cnt      <= '0;
                        result_valid <= 1'b0;
                        for (int unsigned i = 0; i < N_INPUTS; i++) begin
                            val[i]  <= bus.in_value[8*i +: 8];
                            lfsr[i] <= seed(i);
                        end
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < N_INPUTS; i++) begin
                        lfsr[i] <= lfsr_step(lfsr[i]);
                    end
                    win_cnt <= win_cnt + 8'd1;
                    if (win_cnt == WIN_LAST) begin
                        drain_cnt <= '0;
                        state     <= (PIPE_DEPTH == 0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 4'd1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    result_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (PIPE_DEPTH == 0) begin : g_no_delay
            assign sample_valid = run;
        end else begin : g_delay
            logic [PIPE_DEPTH-1:0] valid_dly;

            // Delay stream_valid so it lines up with the bit the network returns
            always_ff @(posedge clk) begin
                if (rst || abort_hit) begin
                    valid_dly <= '0;
                end else begin
                    valid_dly <= PIPE_DEPTH'({valid_dly, run});
                end
            end

            assign sample_valid = valid_dly[PIPE_DEPTH-1];
        end
    endgenerate

    // Count returned 1s belonging to the current window
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if ((state == IDLE) && bus.start) begin
            acc <= '0;
        end else if (sample_valid && bus.net_bit) begin
            acc <= acc + 8'd1;
        end
    end

    // Stochastic bit per input: 1 when the LFSR value does not exceed the input value
    always_comb begin
        in_bits = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            in_bits[i] = run && (lfsr[i] <= val[i]);
        end
    end

    assign bus.in_bits      = in_bits;
    assign bus.stream_valid = run;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.result       = acc;
    assign bus.result_valid = result_valid;
endmodule
